// File: rtl/accum_pass_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : accum_pass_sequencer_if
// Description : Bundle of command, bias-load, row-stream, accumulator-strobe
//               and output-FIFO signals between the accumulator pass
//               sequencer and its surroundings.
//               master : sequencer side (drives the o_* signals)
//               slave  : environment side (drives the i_* signals)
//               Ports  : command (i_start, i_base_addr, i_len, i_passes,
//               o_busy, o_done, o_cmd_err), bias load (i_bias_valid,
//               o_prepare_weight, o_set_bias), row stream (i_row_valid,
//               o_row_req), accumulator (o_rd_en, o_rd_addr, o_bias_mode,
//               o_wr_en), output FIFO (o_execute_out_fifo_wr_en,
//               i_execute_out_fifo_rd_en), status (o_pass_idx).
// Revision    : 1.0 - initial release
// ============================================================================
interface accum_pass_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 9,
    parameter int PASS_WIDTH = 8
) ();
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [LEN_WIDTH-1:0]  i_len;
    logic [PASS_WIDTH-1:0] i_passes;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_cmd_err;
    logic                  i_bias_valid;
    logic                  o_prepare_weight;
    logic                  o_set_bias;
    logic                  i_row_valid;
    logic                  o_row_req;
    logic                  o_rd_en;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic                  o_bias_mode;
    logic                  o_wr_en;
    logic                  o_execute_out_fifo_wr_en;
    logic                  i_execute_out_fifo_rd_en;
    logic [PASS_WIDTH-1:0] o_pass_idx;

    modport master (
        input  i_start, i_base_addr, i_len, i_passes,
        input  i_bias_valid, i_row_valid, i_execute_out_fifo_rd_en,
        output o_busy, o_done, o_cmd_err, o_prepare_weight, o_set_bias,
        output o_row_req, o_rd_en, o_rd_addr, o_bias_mode, o_wr_en,
        output o_execute_out_fifo_wr_en, o_pass_idx
    );

    modport slave (
        output i_start, i_base_addr, i_len, i_passes,
        output i_bias_valid, i_row_valid, i_execute_out_fifo_rd_en,
        input  o_busy, o_done, o_cmd_err, o_prepare_weight, o_set_bias,
        input  o_row_req, o_rd_en, o_rd_addr, o_bias_mode, o_wr_en,
        input  o_execute_out_fifo_wr_en, o_pass_idx
    );
endinterface
`default_nettype wire

// File: rtl/accum_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : accum_pass_sequencer
// Description : Tile sequencer for the dual FP32 accumulator slice. Accepts a
//               tile command, loads the per-column bias, streams row reads
//               for each K-pass (bias mode on pass 0), delays write and
//               result strobes to match the adder/BRAM pipeline, throttles
//               last-pass issue against output-FIFO credits and pulses done.
//               Ports : clk, rst_n (async, active-low), bus (master modport
//               of accum_pass_sequencer_if carrying all command/data strobes).
// Revision    : 1.0 - initial release
// ============================================================================
module accum_pass_sequencer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int LEN_WIDTH      = 9,
    parameter int PASS_WIDTH     = 8,
    parameter int ACC_LATENCY    = 7,
    parameter int OUT_FIFO_DEPTH = 64
) (
    input  wire                     clk,
    input  wire                     rst_n,
    accum_pass_sequencer_if.master  bus
);

    localparam int OCC_W = $clog2(OUT_FIFO_DEPTH + 1);

    localparam logic [LEN_WIDTH-1:0] c_gap_span  = LEN_WIDTH'(ACC_LATENCY + 1);
    localparam logic [LEN_WIDTH-1:0] c_drain_cnt = LEN_WIDTH'(ACC_LATENCY - 1);
    localparam logic [OCC_W-1:0]     c_depth     = OCC_W'(OUT_FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_SET   = 3'd2,
        S_RUN   = 3'd3,
        S_GAP   = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [PASS_WIDTH-1:0] r_passes;
    logic [LEN_WIDTH-1:0]  r_row;
    logic [PASS_WIDTH-1:0] r_pass;
    logic [LEN_WIDTH-1:0]  r_cnt;       // shared GAP / DRAIN countdown
    logic [OCC_W-1:0]      r_occ;       // output FIFO occupancy incl. reservations

    logic                  r_busy;
    logic                  r_done;
    logic                  r_cmd_err;
    logic                  r_set_bias;
    logic                  r_rd_en;
    logic                  r_rd_last;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_bias_mode;

    logic [ACC_LATENCY-1:0] r_pipe_rd;
    logic [ACC_LATENCY-1:0] r_pipe_last;

    logic                  w_row_req;
    logic                  w_prepare;
    logic                  w_xfer;
    logic                  w_last_pass;
    logic                  w_last_row;
    logic                  w_credits_zero;
    logic                  w_cmd_zero;
    logic                  w_accept;
    logic [LEN_WIDTH-1:0]  w_gap_len;
    logic                  w_occ_inc;
    logic                  w_occ_dec;

    assign w_last_pass    = (r_pass == r_passes - PASS_WIDTH'(1));
    assign w_last_row     = (r_row == r_len - LEN_WIDTH'(1));
    assign w_credits_zero = (r_occ == c_depth);
    assign w_cmd_zero     = (bus.i_len == '0) || (bus.i_passes == '0);
    assign w_accept       = (r_state == S_IDLE) && bus.i_start;
    assign w_xfer         = w_row_req && bus.i_row_valid;

    // Short passes need idle cycles so the first row of the next pass is not
    // read before the write of the same row from this pass has landed.
    assign w_gap_len = (r_len >= c_gap_span) ? '0 : (c_gap_span - r_len);

    // Credits are reserved when a last-pass row is issued, not when its
    // result reaches the FIFO, so in-flight results can never overflow it.
    assign w_occ_inc = w_xfer && w_last_pass;
    assign w_occ_dec = bus.i_execute_out_fifo_rd_en && (r_occ != '0);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and combinational outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_row_req    = 1'b0;
        w_prepare    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_state_next = w_cmd_zero ? S_DONE : S_BIAS;
                end
            end
            S_BIAS: begin
                w_prepare = bus.i_bias_valid;
                if (bus.i_bias_valid) begin
                    w_state_next = S_SET;
                end
            end
            S_SET: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                w_row_req = !(w_last_pass && w_credits_zero);
                if (w_row_req && bus.i_row_valid && w_last_row) begin
                    w_state_next = w_last_pass ? S_DRAIN : S_GAP;
                end
            end
            S_GAP: begin
                // A loaded count of 0 or 1 both mean a single GAP cycle.
                if (r_cnt <= LEN_WIDTH'(1)) begin
                    w_state_next = S_RUN;
                end
            end
            S_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath, registered outputs and write-strobe delay line
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_len       <= '0;
            r_passes    <= '0;
            r_row       <= '0;
            r_pass      <= '0;
            r_cnt       <= '0;
            r_occ       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_set_bias  <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_addr   <= '0;
            r_bias_mode <= 1'b0;
            r_pipe_rd   <= '0;
            r_pipe_last <= '0;
        end else begin
            if (w_accept) begin
                r_base   <= bus.i_base_addr;
                r_len    <= bus.i_len;
                r_passes <= bus.i_passes;
                r_row    <= '0;
                r_pass   <= '0;
            end

            if (w_xfer) begin
                // Row index is narrowed to the BRAM width so the address wraps.
                r_rd_addr <= r_base + r_row[ADDR_WIDTH-1:0];
                if (w_last_row) begin
                    if (!w_last_pass) begin
                        r_pass <= r_pass + PASS_WIDTH'(1);
                        r_row  <= '0;
                        r_cnt  <= w_gap_len;
                    end else begin
                        r_cnt  <= c_drain_cnt;
                    end
                end else begin
                    r_row <= r_row + LEN_WIDTH'(1);
                end
            end else if ((r_state == S_GAP || r_state == S_DRAIN) && r_cnt != '0) begin
                r_cnt <= r_cnt - LEN_WIDTH'(1);
            end

            r_rd_en     <= w_xfer;
            r_rd_last   <= w_xfer && w_last_pass;
            r_bias_mode <= w_xfer && (r_pass == '0);

            r_busy      <= (w_state_next != S_IDLE);
            r_done      <= (w_state_next == S_DONE);
            r_set_bias  <= (w_state_next == S_SET);
            r_cmd_err   <= w_accept && w_cmd_zero;

            r_pipe_rd   <= (r_pipe_rd << 1)   | ACC_LATENCY'(r_rd_en);
            r_pipe_last <= (r_pipe_last << 1) | ACC_LATENCY'(r_rd_last);

            if (w_occ_inc && !w_occ_dec) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!w_occ_inc && w_occ_dec) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    assign bus.o_busy                   = r_busy;
    assign bus.o_done                   = r_done;
    assign bus.o_cmd_err                = r_cmd_err;
    assign bus.o_prepare_weight         = w_prepare;
    assign bus.o_set_bias               = r_set_bias;
    assign bus.o_row_req                = w_row_req;
    assign bus.o_rd_en                  = r_rd_en;
    assign bus.o_rd_addr                = r_rd_addr;
    assign bus.o_bias_mode              = r_bias_mode;
    assign bus.o_wr_en                  = r_pipe_rd[ACC_LATENCY-1];
    assign bus.o_execute_out_fifo_wr_en = r_pipe_rd[ACC_LATENCY-1] & r_pipe_last[ACC_LATENCY-1];
    assign bus.o_pass_idx               = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_accum_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_pass_sequencer
// Description : Directed self-checking bench for accum_pass_sequencer. A
//               negedge monitor logs every strobe with its cycle number; each
//               test compares the logs with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_pass_sequencer;

    localparam int LAT = 7;

    logic clk;
    logic rst_n;

    accum_pass_sequencer_if #(.ADDR_WIDTH(8), .LEN_WIDTH(9), .PASS_WIDTH(8)) bus ();

    accum_pass_sequencer #(
        .ADDR_WIDTH(8), .LEN_WIDTH(9), .PASS_WIDTH(8),
        .ACC_LATENCY(LAT), .OUT_FIFO_DEPTH(64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // strobe logs
    int         cyc = 0;
    int         rd_cyc[$];
    logic [7:0] rd_addr_q[$];
    logic       rd_bias_q[$];
    int         wr_cyc[$];
    int         push_cyc[$];
    int         n_done, n_cerr, n_prep, n_set, busy_cnt, start_cyc, done_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.o_rd_en) begin
                rd_cyc.push_back(cyc);
                rd_addr_q.push_back(bus.o_rd_addr);
                rd_bias_q.push_back(bus.o_bias_mode);
            end
            if (bus.o_wr_en)                  wr_cyc.push_back(cyc);
            if (bus.o_execute_out_fifo_wr_en) push_cyc.push_back(cyc);
            if (bus.o_done)           begin n_done++; done_cyc = cyc; end
            if (bus.o_cmd_err)        n_cerr++;
            if (bus.o_prepare_weight) n_prep++;
            if (bus.o_set_bias)       n_set++;
            if (bus.o_busy)           busy_cnt++;
            if (bus.i_start)          start_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_cyc.delete(); rd_addr_q.delete(); rd_bias_q.delete();
        wr_cyc.delete(); push_cyc.delete();
        n_done = 0; n_cerr = 0; n_prep = 0; n_set = 0; busy_cnt = 0;
        start_cyc = 0; done_cyc = 0;
    endtask

    task automatic issue(input logic [7:0] base, input logic [8:0] len, input logic [7:0] passes);
        bus.i_base_addr = base;
        bus.i_len       = len;
        bus.i_passes    = passes;
        bus.i_start     = 1'b1;
        tick();
        bus.i_start     = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (n_done != 0) break;
            tick();
        end
    endtask

    task automatic run_tile(input logic [7:0] base, input logic [8:0] len, input logic [7:0] passes);
        clear_logs();
        issue(base, len, passes);
        wait_done(600);
        repeat (12) tick();
    endtask

    task automatic check_reads(input string t, input int base, input int len, input int passes);
        int n;
        n = len * passes;
        chk({t, " rd count"}, rd_cyc.size(), n);
        for (int i = 0; i < n && i < rd_cyc.size(); i++) begin
            chk($sformatf("%s addr[%0d]", t, i), rd_addr_q[i], (base + (i % len)) % 256);
            chk($sformatf("%s bias[%0d]", t, i), rd_bias_q[i], (i < len) ? 1 : 0);
        end
        chk({t, " wr count"}, wr_cyc.size(), n);
        for (int i = 0; i < wr_cyc.size() && i < rd_cyc.size(); i++)
            chk($sformatf("%s wr lag[%0d]", t, i), wr_cyc[i] - rd_cyc[i], LAT);
        chk({t, " push count"}, push_cyc.size(), len);
        if (rd_cyc.size() == n)
            for (int j = 0; j < push_cyc.size() && j < len; j++)
                chk($sformatf("%s push lag[%0d]", t, j), push_cyc[j] - rd_cyc[n - len + j], LAT);
        chk({t, " prepare"}, n_prep, 1);
        chk({t, " set_bias"}, n_set, 1);
        chk({t, " done"}, n_done, 1);
        chk({t, " cmd_err"}, n_cerr, 0);
    endtask

    initial begin
        rst_n                        = 1'b0;
        bus.i_start                  = 1'b0;
        bus.i_base_addr              = '0;
        bus.i_len                    = '0;
        bus.i_passes                 = '0;
        bus.i_bias_valid             = 1'b1;
        bus.i_row_valid              = 1'b1;
        bus.i_execute_out_fifo_rd_en = 1'b1;
        clear_logs();
        repeat (3) tick();

        // reset state
        chk("reset outputs",
            {bus.o_busy, bus.o_done, bus.o_cmd_err, bus.o_set_bias, bus.o_row_req,
             bus.o_rd_en, bus.o_bias_mode, bus.o_wr_en, bus.o_execute_out_fifo_wr_en,
             bus.o_prepare_weight}, 0);
        chk("reset rd_addr", bus.o_rd_addr, 0);
        chk("reset pass_idx", bus.o_pass_idx, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // single pass, bias loaded immediately
        run_tile(8'd0, 9'd16, 8'd1);
        check_reads("t1", 0, 16, 1);
        chk("t1 tile time", done_cyc - start_cyc, 26);
        chk("t1 busy cycles", busy_cnt, 26);
        chk("t1 busy after", bus.o_busy, 0);

        // three passes, long rows: one-cycle GAP
        run_tile(8'd4, 9'd8, 8'd3);
        check_reads("t2", 4, 8, 3);
        if (rd_cyc.size() == 24) begin
            chk("t2 gap0", rd_cyc[8] - rd_cyc[7], 2);
            chk("t2 gap1", rd_cyc[16] - rd_cyc[15], 2);
        end
        chk("t2 tile time", done_cyc - start_cyc, 36);

        // short rows: GAP of 5 idle cycles
        run_tile(8'd0, 9'd3, 8'd2);
        check_reads("t3", 0, 3, 2);
        if (rd_cyc.size() == 6 && wr_cyc.size() >= 1) begin
            chk("t3 gap", rd_cyc[3] - rd_cyc[2], 6);
            chk("t3 read after write", rd_cyc[3] > wr_cyc[0], 1);
        end
        chk("t3 tile time", done_cyc - start_cyc, 21);

        // address wrap
        run_tile(8'd250, 9'd10, 8'd1);
        check_reads("t4", 250, 10, 1);

        // zero-pass command
        run_tile(8'd0, 9'd5, 8'd0);
        chk("t5 cmd_err", n_cerr, 1);
        chk("t5 done", n_done, 1);
        chk("t5 strobes", rd_cyc.size() + wr_cyc.size() + push_cyc.size() + n_prep + n_set, 0);
        chk("t5 busy cycles", busy_cnt, 1);

        // credit exhaustion with no pops
        repeat (4) tick();
        bus.i_execute_out_fifo_rd_en = 1'b0;
        clear_logs();
        issue(8'd0, 9'd80, 8'd1);
        repeat (120) tick();
        chk("t6 rd before pops", rd_cyc.size(), 64);
        chk("t6 row_req low", bus.o_row_req, 0);
        repeat (20) tick();
        chk("t6 rd stalled", rd_cyc.size(), 64);
        for (int k = 1; k <= 8; k++) begin
            bus.i_execute_out_fifo_rd_en = 1'b1;
            tick();
            bus.i_execute_out_fifo_rd_en = 1'b0;
            repeat (4) tick();
            chk($sformatf("t6 rd after pop %0d", k), rd_cyc.size(), 64 + k);
        end
        bus.i_execute_out_fifo_rd_en = 1'b1;
        wait_done(300);
        repeat (12) tick();
        chk("t6 rd total", rd_cyc.size(), 80);
        chk("t6 push total", push_cyc.size(), 80);
        chk("t6 done", n_done, 1);

        // asynchronous reset in the middle of RUN
        clear_logs();
        issue(8'd0, 9'd16, 8'd2);
        for (int i = 0; i < 100; i++) begin
            if (rd_cyc.size() >= 5) break;
            tick();
        end
        chk("t7 reached run", rd_cyc.size() >= 5, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7 outputs in reset",
            {bus.o_busy, bus.o_done, bus.o_cmd_err, bus.o_set_bias, bus.o_row_req,
             bus.o_rd_en, bus.o_bias_mode, bus.o_wr_en, bus.o_execute_out_fifo_wr_en,
             bus.o_prepare_weight}, 0);
        chk("t7 rd_addr in reset", bus.o_rd_addr, 0);
        chk("t7 pass_idx in reset", bus.o_pass_idx, 0);
        clear_logs();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("t7 no late wr", wr_cyc.size(), 0);
        chk("t7 no late push", push_cyc.size(), 0);
        chk("t7 no reads", rd_cyc.size(), 0);
        chk("t7 idle", bus.o_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/accum_pass_sequencer.md
# accum_pass_sequencer

Sequencer for the dual FP32 accumulator slice. It takes one tile command (base address, row count, pass count) and loads the per-column bias through the weight-load path. It then streams row addresses into the accumulator for every K-pass, using bias mode on the first pass. It delays write strobes to match the adder/BRAM pipeline, gates final results into the 64-deep output FIFO using a credit count, and reports completion.

## Interface
- ADDR_WIDTH, 8, accumulator BRAM address width
- LEN_WIDTH, 9, row-count width (max rows = 2^ADDR_WIDTH)
- PASS_WIDTH, 8, pass-count width
- ACC_LATENCY, 7, cycles from read strobe to matching write/result strobe
- OUT_FIFO_DEPTH, 64, output FIFO entries (credit pool)
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  command strobe, accepted only in IDLE
- i_base_addr  in  ADDR_WIDTH  first row address
- i_len  in  LEN_WIDTH  rows per pass
- i_passes  in  PASS_WIDTH  number of K-passes
- o_busy  out  1  high from accepted command until done
- o_done  out  1  one-cycle completion pulse
- o_cmd_err  out  1  one-cycle pulse, zero-length command
- i_bias_valid  in  1  bias word present on weight-load bus
- o_prepare_weight  out  1  capture weight-load bus into bias staging
- o_set_bias  out  1  transfer staging into bias register
- i_row_valid  in  1  array has a partial-sum row ready
- o_row_req  out  1  controller can consume a row this cycle
- o_rd_en  out  1  accumulator read strobe
- o_rd_addr  out  ADDR_WIDTH  accumulator read address
- o_bias_mode  out  1  adder uses bias instead of accumulator value
- o_wr_en  out  1  accumulator write strobe (o_rd_en delayed ACC_LATENCY)
- o_execute_out_fifo_wr_en  out  1  final-result push (last-pass o_rd_en delayed ACC_LATENCY)
- i_execute_out_fifo_rd_en  in  1  consumer pop of output FIFO
- o_pass_idx  out  PASS_WIDTH  current pass number, 0-based

## Operation
- States: IDLE, BIAS, SET, RUN, GAP, DRAIN, DONE.
- IDLE: on i_start, latch base, len and passes. Clear the row index and pass index, then go to BIAS. If len==0 or passes==0, go to DONE with o_cmd_err. i_start outside IDLE is ignored.
- BIAS: o_prepare_weight = i_bias_valid. Move to SET on the first cycle i_bias_valid=1.
- SET: o_set_bias=1 for exactly one cycle, then go to RUN.
- RUN: o_row_req=1 unless the current pass is the last pass and credits==0. A transfer occurs when i_row_valid && o_row_req. On a transfer, drive o_rd_en=1 and o_rd_addr=(base+row) mod 2^ADDR_WIDTH. Drive o_bias_mode=1 iff pass==0. Then increment row.
- On the transfer with row==len-1: if more passes remain, increment pass, clear row, and go to GAP. Otherwise go to DRAIN.
- GAP: insert max(0, ACC_LATENCY+1-len) idle cycles so a read never meets its own pending write. Go to RUN when the count is exhausted. Zero cycles means GAP lasts one cycle.
- DRAIN: wait ACC_LATENCY cycles for the write pipe to empty, then go to DONE.
- DONE: o_done=1 for one cycle, then go to IDLE. o_busy is 1 in every state except IDLE.
- Delay lines: a shift register of ACC_LATENCY stages carries {rd_en, last_pass}. Its output drives o_wr_en and o_execute_out_fifo_wr_en (= rd_en & last_pass).
- Credits: occupancy increments on each last-pass transfer, i.e. it is reserved at issue. It decrements on i_execute_out_fifo_rd_en when occupancy>0. A simultaneous increment and decrement leaves it unchanged. credits = OUT_FIFO_DEPTH − occupancy. Occupancy persists across commands.

## Timing
- All outputs are registered except o_row_req and o_prepare_weight, which are combinational from state and inputs.
- Reset values: all outputs 0, state IDLE, delay lines cleared, occupancy 0. An asynchronous reset mid-tile issues no further strobes, including pending writes.
- o_rd_en/o_rd_addr/o_bias_mode are asserted in the cycle after the transfer handshake.
- o_wr_en follows the o_rd_en that caused it by exactly ACC_LATENCY cycles.
- Minimum tile time for len≥8, no stalls: 1 (BIAS) + 1 (SET) + P·len + (P−1) (GAP) + ACC_LATENCY + 1 (DONE).
- Address wrap: base=250, len=10 gives addresses 250..255 then 0..3.
- When the credit count reaches 0 mid-pass, o_row_req drops the same cycle. Issue resumes the cycle after a pop.

## Test plan
- base=0, len=16, passes=1, bias valid immediately: one prepare_weight, then set_bias. 16 reads 0..15 with bias_mode=1. 16 wr_en and 16 fifo pushes, each 7 cycles after its read. o_done once.
- base=4, len=8, passes=3: bias_mode=1 only on pass 0. Fifo pushes only on pass 2 (8 pushes). 24 wr_en. GAP is one cycle.
- len=3, passes=2: GAP inserts 5 idle cycles. The second-pass read of addr 0 occurs after its first-pass write.
- base=250, len=10: rd_addr sequence 250..255,0..3.
- len=80, passes=1, no pops: exactly 64 transfers, then o_row_req stays low. After each pop, exactly one more transfer.
- i_passes=0: o_cmd_err and o_done pulse, no rd/wr/fifo strobes. Also assert rst_n low mid-RUN: all outputs 0 immediately, no later wr_en.
